// File: rtl/mem_responder.sv
// Word-addressed memory target on a shared tri-state data bus.
// Fixed-latency handshake: IDLE samples a request, WAIT stalls, DONE pulses ready.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    inout  wire  [31:0] bus,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        ready,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_rd;
    logic        req_wr;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata;
    logic        fault_q;
    logic        rd_ok;

    logic        strobe;
    logic        take;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic        acc_rd;
    logic        acc_wr;
    logic        reject;
    logic [AW-1:0] acc_idx;
    logic        enter_done;

    assign strobe = mem_read | mem_write;
    assign take   = (state == IDLE) && strobe;

    // With no wait cycles, DONE is entered on the sampling edge itself,
    // so the access must see the live inputs rather than the latches.
    assign acc_addr = (state == IDLE) ? addr      : req_addr;
    assign acc_data = (state == IDLE) ? bus       : req_data;
    assign acc_rd   = (state == IDLE) ? mem_read  : req_rd;
    assign acc_wr   = (state == IDLE) ? mem_write : req_wr;
    assign acc_idx  = acc_addr[AW+1:2];

    assign reject = (|acc_addr[1:0])
                  || (|(acc_addr >> (AW + 2)))
                  || (acc_rd && acc_wr);

    assign enter_done = (state_nx == DONE) && (state != DONE) && !reset;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (strobe) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_addr <= 32'd0;
            req_data <= 32'd0;
            req_rd   <= 1'b0;
            req_wr   <= 1'b0;
            fault_q  <= 1'b0;
            rd_ok    <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            fault_q <= enter_done && reject;
            rd_ok   <= enter_done && acc_rd && !reject;
            if (take) begin
                req_addr <= addr;
                req_data <= bus;
                req_rd   <= mem_read;
                req_wr   <= mem_write;
            end
            if (enter_done && acc_rd && !reject) begin
                rdata <= mem[acc_idx];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enter_done && acc_wr && !reject) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign ready = (state == DONE);
    assign fault = fault_q;
    assign bus   = ((state == DONE) && rd_ok && mem_read) ? rdata : 'z;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder.
// Three instances cover WAIT_CYCLES of 0, 1 and 15 with DEPTH=256.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] addr_a [3];
    logic        rd_a   [3];
    logic        wr_a   [3];
    logic        drv_a  [3];
    logic [31:0] wd_a   [3];
    logic        ready_a[3];
    logic        fault_a[3];
    logic [31:0] bus_a  [3];

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] mdl [3][256];
    bit          mv  [3][256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 15);
        wire [31:0] bus;
        logic       rdy;
        logic       flt;
        pullup (bus);
        assign bus = drv_a[g] ? wd_a[g] : 'z;
        assign bus_a[g]   = bus;
        assign ready_a[g] = rdy;
        assign fault_a[g] = flt;
        mem_responder #(
            .DEPTH(256),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .addr(addr_a[g]),
            .bus(bus),
            .mem_read(rd_a[g]),
            .mem_write(wr_a[g]),
            .ready(rdy),
            .fault(flt)
        );
    end

    function automatic int wc(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 1 : 15);
    endfunction

    function automatic bit bad(input bit rd, input bit wr, input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024) || (rd && wr);
    endfunction

    // Issue one request, return latency in edges, fault and bus seen in DONE.
    task automatic do_req(input int s, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int drop_at,
                          output int lat, output bit flt,
                          output logic [31:0] bdone, output bit z_ok);
        lat   = -1;
        flt   = 1'b0;
        bdone = '1;
        z_ok  = 1'b1;
        @(negedge clk);
        addr_a[s] = a;
        rd_a[s]   = rd;
        wr_a[s]   = wr;
        wd_a[s]   = wd;
        drv_a[s]  = wr;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == drop_at) begin
                rd_a[s]  = 1'b0;
                wr_a[s]  = 1'b0;
                drv_a[s] = 1'b0;
            end
            #1;
            if (ready_a[s]) begin
                lat   = n;
                flt   = fault_a[s];
                bdone = bus_a[s];
                break;
            end
            if (!drv_a[s] && bus_a[s] !== '1) z_ok = 1'b0;
        end
        rd_a[s]  = 1'b0;
        wr_a[s]  = 1'b0;
        drv_a[s] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            addr_a[s] = '0; rd_a[s] = 0; wr_a[s] = 0;
            drv_a[s] = 0; wd_a[s] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            total++;
            if (ready_a[s] !== 1'b0) $display("FAIL rst_ready[%0d] got %b want 0", s, ready_a[s]);
            else pass_cnt++;
            total++;
            if (fault_a[s] !== 1'b0) $display("FAIL rst_fault[%0d] got %b want 0", s, fault_a[s]);
            else pass_cnt++;
            total++;
            if (bus_a[s] !== '1) $display("FAIL rst_bus[%0d] got %h want released", s, bus_a[s]);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        addr_a[0] = 32'h40; wr_a[0] = 1; wd_a[0] = 32'h01020304; drv_a[0] = 1;
        @(negedge clk);
        #1;
        total++;
        if (ready_a[0] !== 1'b1 || fault_a[0] !== 1'b0)
            $display("FAIL first_sample got ready=%b fault=%b want 1/0", ready_a[0], fault_a[0]);
        else pass_cnt++;
        wr_a[0] = 0; drv_a[0] = 0;
        mdl[0][16] = 32'h01020304; mv[0][16] = 1;
    endtask

    task automatic test_write_read();
        int lat; bit flt; logic [31:0] b; bit z;
        do_req(1, 0, 1, 32'h10, 32'hDEADBEEF, -1, lat, flt, b, z);
        mdl[1][4] = 32'hDEADBEEF; mv[1][4] = 1;
        total++;
        if (lat != 2 || flt) $display("FAIL wr_lat got lat=%0d fault=%b want 2/0", lat, flt);
        else pass_cnt++;
        do_req(1, 1, 0, 32'h10, 32'h0, -1, lat, flt, b, z);
        total++;
        if (lat != 2 || flt) $display("FAIL rd_lat got lat=%0d fault=%b want 2/0", lat, flt);
        else pass_cnt++;
        total++;
        if (b !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", b);
        else pass_cnt++;
        total++;
        if (!z) $display("FAIL rd_wait_bus got driven want released");
        else pass_cnt++;
    endtask

    task automatic test_faults();
        int lat; bit flt; logic [31:0] b; bit z;
        do_req(1, 0, 1, 32'h0, 32'h0BADF00D, -1, lat, flt, b, z);
        mdl[1][0] = 32'h0BADF00D; mv[1][0] = 1;
        do_req(1, 1, 0, 32'h2, 32'h0, -1, lat, flt, b, z);
        total++;
        if (lat != 2 || flt !== 1'b1) $display("FAIL misalign got lat=%0d fault=%b want 2/1", lat, flt);
        else pass_cnt++;
        total++;
        if (b !== '1 || !z) $display("FAIL misalign_bus got %h want released", b);
        else pass_cnt++;
        do_req(1, 0, 1, 32'h400, 32'h11111111, -1, lat, flt, b, z);
        total++;
        if (lat != 2 || flt !== 1'b1) $display("FAIL range got lat=%0d fault=%b want 2/1", lat, flt);
        else pass_cnt++;
        do_req(1, 1, 1, 32'h0, 32'h55AA55AA, -1, lat, flt, b, z);
        total++;
        if (lat != 2 || flt !== 1'b1) $display("FAIL both got lat=%0d fault=%b want 2/1", lat, flt);
        else pass_cnt++;
        do_req(1, 1, 0, 32'h0, 32'h0, -1, lat, flt, b, z);
        total++;
        if (flt || b !== mdl[1][0]) $display("FAIL word0_kept got %h fault=%b want %h", b, flt, mdl[1][0]);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        int lat; bit flt; logic [31:0] b; bit z;
        for (int s = 0; s < 3; s += 2) begin
            do_req(s, 0, 1, 32'h8, 32'h600D0000 + s, -1, lat, flt, b, z);
            mdl[s][2] = 32'h600D0000 + s; mv[s][2] = 1;
            do_req(s, 1, 0, 32'h8, 32'h0, -1, lat, flt, b, z);
            total++;
            if (lat != wc(s) + 1) $display("FAIL lat[%0d] got %0d want %0d", s, lat, wc(s) + 1);
            else pass_cnt++;
            total++;
            if (b !== mdl[s][2]) $display("FAIL lat_data[%0d] got %h want %h", s, b, mdl[s][2]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit flt; logic [31:0] b; bit z;
        bit seen;
        do_req(1, 0, 1, 32'h20, 32'hCAFE0001, -1, lat, flt, b, z);
        mdl[1][8] = 32'hCAFE0001; mv[1][8] = 1;
        @(negedge clk);
        addr_a[1] = 32'h20; wr_a[1] = 1; wd_a[1] = 32'h12345678; drv_a[1] = 1;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            #1;
            if (ready_a[1]) seen = 1;
            @(negedge clk);
        end
        wr_a[1] = 0; drv_a[1] = 0;
        reset = 1'b0;
        total++;
        if (seen) $display("FAIL abort_ready got pulse want none");
        else pass_cnt++;
        do_req(1, 1, 0, 32'h20, 32'h0, -1, lat, flt, b, z);
        total++;
        if (b !== 32'hCAFE0001) $display("FAIL abort_data got %h want cafe0001", b);
        else pass_cnt++;
    endtask

    task automatic test_strobe_drop();
        int lat; bit flt; logic [31:0] b; bit z;
        do_req(2, 1, 0, 32'h8, 32'h0, 3, lat, flt, b, z);
        total++;
        if (lat != 16) $display("FAIL drop_lat got %0d want 16", lat);
        else pass_cnt++;
        total++;
        if (b !== '1 || !z) $display("FAIL drop_bus got %h want released", b);
        else pass_cnt++;
        do_req(1, 0, 1, 32'h30, 32'h77001122, 1, lat, flt, b, z);
        mdl[1][12] = 32'h77001122; mv[1][12] = 1;
        do_req(1, 1, 0, 32'h30, 32'h0, -1, lat, flt, b, z);
        total++;
        if (b !== 32'h77001122) $display("FAIL drop_wr got %h want 77001122", b);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        first = -1;
        second = -1;
        @(negedge clk);
        addr_a[1] = 32'h44; wr_a[1] = 1; wd_a[1] = 32'h0A0B0C0D; drv_a[1] = 1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            #1;
            if (ready_a[1]) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        wr_a[1] = 0; drv_a[1] = 0;
        mdl[1][17] = 32'h0A0B0C0D; mv[1][17] = 1;
        total++;
        if (first != 2 || second - first != 3)
            $display("FAIL b2b got first=%0d gap=%0d want 2/3", first, second - first);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat; bit flt; logic [31:0] b; bit z;
        int s; bit rd; bit wr; logic [31:0] a; logic [31:0] d;
        int w; int k; bit ef;
        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 2);
            w = $urandom_range(0, 255);
            a = 32'(w * 4);
            k = $urandom_range(0, 15);
            if (k == 0) a = a + 32'($urandom_range(1, 3));
            if (k == 1) a = 32'd1024 + 32'($urandom_range(0, 4000) * 4);
            rd = $urandom_range(0, 1) == 1;
            wr = !rd;
            if (k == 2) begin rd = 1; wr = 1; end
            if (rd && !wr && !bad(rd, wr, a) && !mv[s][w]) begin rd = 0; wr = 1; end
            d = $urandom & 32'h7FFF_FFFF;
            ef = bad(rd, wr, a);
            do_req(s, rd, wr, a, d, -1, lat, flt, b, z);
            total++;
            if (lat != wc(s) + 1 || flt !== ef)
                $display("FAIL rnd%0d got lat=%0d fault=%b want %0d/%b", i, lat, flt, wc(s) + 1, ef);
            else pass_cnt++;
            if (rd && !wr) begin
                total++;
                if (!ef && b !== mdl[s][w])
                    $display("FAIL rnd%0d_data got %h want %h", i, b, mdl[s][w]);
                else if (ef && b !== '1)
                    $display("FAIL rnd%0d_bus got %h want released", i, b);
                else pass_cnt++;
            end
            if (wr && !ef) begin
                mdl[s][w] = d;
                mv[s][w] = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_faults();
        test_latency();
        test_reset_abort();
        test_strobe_drop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
